// File: rtl/warp_fetch_scheduler.sv
// Dual-lane round-robin warp picker for instruction fetch: tracks IBuffer credits,
// masks warps held off by PC flushes, and registers two distinct one-hot grants.
module warp_fetch_scheduler #(
    parameter int IBUF_DEPTH = 2,
    parameter int FLUSH_HOLD = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] Active_SIMT_FS,
    input  logic       Stall_IF,
    input  logic [7:0] Dequeue_IB_FS,
    input  logic [7:0] UpdatePC_Qual1_SIMT_IF,
    input  logic [7:0] UpdatePC_Qual2_SIMT_IF,
    input  logic [7:0] UpdatePC_Qual3_ID0_IF,
    input  logic [7:0] UpdatePC_Qual3_ID1_IF,
    output logic [7:0] GRT_raw_1_RR_IF,
    output logic [7:0] GRT_raw_2_RR_IF,
    output logic [7:0] Eligible_FS
);
    localparam int CW = $clog2(IBUF_DEPTH + 1);
    localparam int HW = $clog2(FLUSH_HOLD + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(IBUF_DEPTH);
    localparam logic [CW-1:0] CREDIT_ONE = CW'(1);
    localparam logic [CW-1:0] CREDIT_ZERO = CW'(0);
    localparam logic [HW-1:0] HOLD_MAX = HW'(FLUSH_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);
    localparam logic [HW-1:0] HOLD_ZERO = HW'(0);

    logic [CW-1:0] credit_r [8];
    logic [HW-1:0] hold_r [8];
    logic [2:0]    rr_ptr_r;
    logic [7:0]    grt1_r;
    logic [7:0]    grt2_r;

    logic [7:0] flush_s;
    logic [7:0] eligible_s;
    logic [3:0] scan1_s;
    logic [3:0] scan2_s;
    logic [7:0] sel1_s;
    logic [7:0] sel2_s;
    logic [7:0] selected_s;
    logic [2:0] rr_next_s;
    logic [7:0] sat_s;

    // First set bit of vec scanning cyclically from start; returns {found, index}.
    function automatic logic [3:0] scan_from(input logic [7:0] vec, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] cand;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            cand = start + 3'(i);
            if (vec[cand]) begin
                res = {1'b1, cand};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign flush_s = UpdatePC_Qual1_SIMT_IF | UpdatePC_Qual2_SIMT_IF |
                     UpdatePC_Qual3_ID0_IF | UpdatePC_Qual3_ID1_IF;

    // Per-warp eligibility and saturating-dequeue detection.
    always_comb begin
        eligible_s = 8'h00;
        sat_s      = 8'h00;
        for (int w = 0; w < 8; w++) begin
            eligible_s[w] = Active_SIMT_FS[w] && (credit_r[w] != CREDIT_ZERO) &&
                            (hold_r[w] == HOLD_ZERO) && !flush_s[w] && !Stall_IF;
            sat_s[w] = !flush_s[w] && (hold_r[w] == HOLD_ZERO) && !selected_s[w] &&
                       Dequeue_IB_FS[w] && (credit_r[w] == CREDIT_MAX);
        end
    end

    // Lane 1 scans from the round-robin pointer; lane 2 continues just past lane 1.
    always_comb begin
        scan1_s = scan_from(eligible_s, rr_ptr_r);
        if (scan1_s[3]) begin
            sel1_s  = 8'h01 << scan1_s[2:0];
            scan2_s = scan_from(eligible_s & ~sel1_s, scan1_s[2:0] + 3'd1);
        end else begin
            sel1_s  = 8'h00;
            scan2_s = 4'b0000;
        end
        if (scan2_s[3]) begin
            sel2_s    = 8'h01 << scan2_s[2:0];
            rr_next_s = scan2_s[2:0] + 3'd1;
        end else if (scan1_s[3]) begin
            sel2_s    = 8'h00;
            rr_next_s = scan1_s[2:0] + 3'd1;
        end else begin
            sel2_s    = 8'h00;
            rr_next_s = rr_ptr_r;
        end
        selected_s = sel1_s | sel2_s;
    end

    // Grant registers, round-robin pointer and per-warp credit/hold state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grt1_r   <= 8'h00;
            grt2_r   <= 8'h00;
            rr_ptr_r <= 3'd0;
            for (int w = 0; w < 8; w++) begin
                credit_r[w] <= CREDIT_MAX;
                hold_r[w]   <= HOLD_ZERO;
            end
        end else begin
            grt1_r   <= sel1_s;
            grt2_r   <= sel2_s;
            rr_ptr_r <= rr_next_s;
            for (int w = 0; w < 8; w++) begin
                if (flush_s[w]) begin
                    credit_r[w] <= CREDIT_MAX;
                    hold_r[w]   <= HOLD_MAX;
                end else if (hold_r[w] != HOLD_ZERO) begin
                    hold_r[w] <= hold_r[w] - HOLD_ONE;
                end else if (selected_s[w] && !Dequeue_IB_FS[w]) begin
                    credit_r[w] <= credit_r[w] - CREDIT_ONE;
                end else if (!selected_s[w] && Dequeue_IB_FS[w] && (credit_r[w] != CREDIT_MAX)) begin
                    credit_r[w] <= credit_r[w] + CREDIT_ONE;
                end else begin
                    credit_r[w] <= credit_r[w];
                end
            end
        end
    end

    assign GRT_raw_1_RR_IF = grt1_r;
    assign GRT_raw_2_RR_IF = grt2_r;
    assign Eligible_FS     = eligible_s;

    warp_fetch_scheduler_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .grt1  (grt1_r),
        .grt2  (grt2_r),
        .sat   (sat_s)
    );
endmodule

// Runtime checks on grant shape and on dequeues arriving at a full credit counter.
module warp_fetch_scheduler_chk (
    input logic       clk,
    input logic       rst_n,
    input logic [7:0] grt1,
    input logic [7:0] grt2,
    input logic [7:0] sat
);
    a_grt1_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grt1));
    a_grt2_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grt2));
    a_grt_distinct: assert property (@(posedge clk) disable iff (!rst_n)
        (grt2 == 8'h00) || ((grt1 != 8'h00) && (grt1 != grt2)));
    a_no_sat_dequeue: assert property (@(posedge clk) disable iff (!rst_n) sat == 8'h00);
endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Directed bench for warp_fetch_scheduler with hand-computed grants and eligibility.
module tb_warp_fetch_scheduler;
    logic       clk;
    logic       rst_n;
    logic [7:0] active;
    logic       stall;
    logic [7:0] deq;
    logic [7:0] q1, q2, q3a, q3b;
    logic [7:0] grt1, grt2, elig;

    int total = 0;
    int bad   = 0;

    warp_fetch_scheduler #(.IBUF_DEPTH(2), .FLUSH_HOLD(2)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .Active_SIMT_FS         (active),
        .Stall_IF               (stall),
        .Dequeue_IB_FS          (deq),
        .UpdatePC_Qual1_SIMT_IF (q1),
        .UpdatePC_Qual2_SIMT_IF (q2),
        .UpdatePC_Qual3_ID0_IF  (q3a),
        .UpdatePC_Qual3_ID1_IF  (q3b),
        .GRT_raw_1_RR_IF        (grt1),
        .GRT_raw_2_RR_IF        (grt2),
        .Eligible_FS            (elig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input logic [7:0] e1, input logic [7:0] e2);
        step();
        chk({tag, "_g1"}, grt1, e1);
        chk({tag, "_g2"}, grt2, e2);
    endtask

    logic [7:0] t1_g1 [9];
    logic [7:0] t1_g2 [9];

    initial begin
        t1_g1 = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h01, 8'h04, 8'h10, 8'h40, 8'h00};
        t1_g2 = '{8'h02, 8'h08, 8'h20, 8'h80, 8'h02, 8'h08, 8'h20, 8'h80, 8'h00};
        rst_n = 1'b0; active = 8'hFF; stall = 1'b0; deq = 8'h00;
        q1 = 8'h00; q2 = 8'h00; q3a = 8'h00; q3b = 8'h00;
        #12;
        chk("rst_g1", grt1, 8'h00);
        chk("rst_g2", grt2, 8'h00);
        chk("rst_elig", elig, 8'hFF);
        rst_n = 1'b1;

        // Drain both credits of every warp in pairs, then nothing left.
        for (int i = 0; i < 9; i++) step_chk($sformatf("t1_c%0d", i), t1_g1[i], t1_g2[i]);
        chk("t1_elig_empty", elig, 8'h00);

        // Refill by reset, run to 10/20, then reset mid-cycle.
        rst_n = 1'b0; #3; rst_n = 1'b1;
        chk("t6_elig_refill", elig, 8'hFF);
        step_chk("t6_a", 8'h01, 8'h02);
        step_chk("t6_b", 8'h04, 8'h08);
        step_chk("t6_c", 8'h10, 8'h20);
        #2; rst_n = 1'b0; #1;
        chk("t6_async_g1", grt1, 8'h00);
        chk("t6_async_g2", grt2, 8'h00);
        #2; rst_n = 1'b1;
        chk("t6_elig_after", elig, 8'hFF);
        step_chk("t6_first", 8'h01, 8'h02);

        // Single active warp with a dequeue each cycle keeps its credit at 1.
        active = 8'h04;
        step_chk("t2_first", 8'h04, 8'h00);
        deq = 8'h04;
        for (int i = 0; i < 3; i++) step_chk($sformatf("t2_d%0d", i), 8'h04, 8'h00);

        // Stall for three cycles, then resume from warp 3.
        active = 8'hFF; deq = 8'h00; stall = 1'b1; #1;
        chk("t5_elig_stall", elig, 8'h00);
        for (int i = 0; i < 3; i++) step_chk($sformatf("t5_s%0d", i), 8'h00, 8'h00);
        stall = 1'b0; #1;
        chk("t5_elig_rel", elig, 8'hFF);
        step_chk("t5_resume", 8'h08, 8'h10);

        // Flush of warp 1 holds it off for three selection cycles.
        q3b = 8'h02; #1;
        chk("t3_elig_t", elig, 8'hFD);
        step_chk("t3_t", 8'h20, 8'h40);
        q3b = 8'h00; deq = 8'h02; #1;
        chk("t3_elig_t1", elig, 8'hFD);
        step_chk("t3_t1", 8'h80, 8'h01);
        deq = 8'h00; #1;
        chk("t3_elig_t2", elig, 8'hFC);
        step_chk("t3_t2", 8'h04, 8'h08);
        chk("t3_elig_t3", elig, 8'hF2);
        step_chk("t3_t3", 8'h10, 8'h20);
        chk("t3_elig_t4", elig, 8'hC2);
        step_chk("t3_t4", 8'h40, 8'h80);
        step_chk("t3_w1a", 8'h02, 8'h00);
        step_chk("t3_w1b", 8'h02, 8'h00);
        step_chk("t3_empty", 8'h00, 8'h00);

        // Flush of warp 3 while its grant is on the outputs restores full credit.
        active = 8'h00; deq = 8'hFF;
        step_chk("t4_refill", 8'h00, 8'h00);
        deq = 8'h00; active = 8'h08; #1;
        chk("t4_elig", elig, 8'h08);
        step_chk("t4_grant", 8'h08, 8'h00);
        q1 = 8'h08; #1;
        chk("t4_grant_kept", grt1, 8'h08);
        chk("t4_elig_flush", elig, 8'h00);
        step_chk("t4_f", 8'h00, 8'h00);
        q1 = 8'h00; #1;
        chk("t4_elig_h2", elig, 8'h00);
        step_chk("t4_h2", 8'h00, 8'h00);
        chk("t4_elig_h1", elig, 8'h00);
        step_chk("t4_h1", 8'h00, 8'h00);
        chk("t4_elig_free", elig, 8'h08);
        step_chk("t4_c2", 8'h08, 8'h00);
        step_chk("t4_c1", 8'h08, 8'h00);
        step_chk("t4_c0", 8'h00, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
